// File: rtl/execute_in_stage.sv
// Execute-stage input buffer: captures decode outputs one cycle after en_decode
// into a small circular FIFO and holds decode off while a control instruction is buffered.
module execute_in_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        Mem_Control,
    input  logic [5:0]  E_Control,
    input  logic [1:0]  W_Control,
    input  logic [15:0] IR,
    input  logic [15:0] npc_out,
    output logic        en_decode,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic        ex_Mem_Control,
    output logic [5:0]  ex_E_Control,
    output logic [1:0]  ex_W_Control,
    output logic [15:0] ex_IR,
    output logic [15:0] ex_npc,
    output logic [15:0] instr_count
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;

    typedef struct packed {
        logic        mem;
        logic [5:0]  e;
        logic [1:0]  w;
        logic [15:0] ir;
        logic [15:0] npc;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [2:0]      count_q, count_d;
    logic [2:0]      ctrl_cnt_q, ctrl_cnt_d;
    logic            pending_q;
    logic [15:0]     instr_count_q, instr_count_d;

    entry_t          head_entry;
    logic            capture;
    logic            pop;
    logic            ctrl_in;
    logic            ctrl_out;
    logic [3:0]      occupancy;

    function automatic logic is_ctrl(input logic [15:0] ir);
        return (ir[15:12] == 4'b0000) || (ir[15:12] == 4'b1100) ||
               (ir[15:12] == 4'b0100) || (ir[15:12] == 4'b1111);
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slots already filled plus the one in flight from decode.
    assign occupancy  = 4'(count_q) + 4'(pending_q);
    assign en_decode  = run && !reset && (ctrl_cnt_q == 3'd0) && (occupancy < 4'(DEPTH));

    assign head_entry = fifo_q[head_q];
    assign ex_valid   = (count_q != 3'd0);
    assign capture    = pending_q;
    assign pop        = ex_valid && ex_ready;
    assign ctrl_in    = capture && is_ctrl(IR);
    assign ctrl_out   = pop && is_ctrl(head_entry.ir);

    assign ex_Mem_Control = ex_valid ? head_entry.mem : 1'b0;
    assign ex_E_Control   = ex_valid ? head_entry.e   : 6'd0;
    assign ex_W_Control   = ex_valid ? head_entry.w   : 2'd0;
    assign ex_IR          = ex_valid ? head_entry.ir  : 16'd0;
    assign ex_npc         = ex_valid ? head_entry.npc : 16'd0;
    assign instr_count    = instr_count_q;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        ctrl_cnt_d    = ctrl_cnt_q;
        instr_count_d = instr_count_q;

        if (capture) begin
            tail_d = next_ptr(tail_q);
        end
        if (pop) begin
            head_d        = next_ptr(head_q);
            instr_count_d = instr_count_q + 16'd1;
        end

        case ({capture, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        case ({ctrl_in, ctrl_out})
            2'b10:   ctrl_cnt_d = ctrl_cnt_q + 3'd1;
            2'b01:   ctrl_cnt_d = ctrl_cnt_q - 3'd1;
            default: ctrl_cnt_d = ctrl_cnt_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= 3'd0;
            ctrl_cnt_q    <= 3'd0;
            pending_q     <= 1'b0;
            instr_count_q <= 16'd0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ctrl_cnt_q    <= ctrl_cnt_d;
            pending_q     <= en_decode;
            instr_count_q <= instr_count_d;
        end
    end

    // Payload storage needs no reset: ex_* outputs are masked while empty.
    always_ff @(posedge clock) begin
        if (!reset && capture) begin
            fifo_q[tail_q] <= '{mem: Mem_Control, e: E_Control, w: W_Control,
                                ir: IR, npc: npc_out};
        end
    end

    overflow_chk: assert property (@(posedge clock) disable iff (reset)
        !(pending_q && (count_q == 3'(DEPTH))));

endmodule

// File: tb/tb_execute_in_stage.sv
// Directed table of per-cycle inputs and expected outputs for the DEPTH=2 instance,
// plus a DEPTH=4 instance driven to the instr_count wrap.
module tb_execute_in_stage;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // DEPTH=2 instance signals
    logic        reset, run, ex_ready;
    logic        mem_c;
    logic [5:0]  e_c;
    logic [1:0]  w_c;
    logic [15:0] ir, npc;
    logic        en_decode, ex_valid, ex_mem;
    logic [5:0]  ex_e;
    logic [1:0]  ex_w;
    logic [15:0] ex_ir, ex_npc, icnt;

    // DEPTH=4 instance signals
    logic        reset2, run2, ready2;
    logic        en2, valid2, ex_mem2;
    logic [5:0]  ex_e2;
    logic [1:0]  ex_w2;
    logic [15:0] ex_ir2, ex_npc2, icnt2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    execute_in_stage #(.DEPTH(2)) dut (
        .clock(clock), .reset(reset), .run(run),
        .Mem_Control(mem_c), .E_Control(e_c), .W_Control(w_c),
        .IR(ir), .npc_out(npc), .en_decode(en_decode),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_Mem_Control(ex_mem), .ex_E_Control(ex_e), .ex_W_Control(ex_w),
        .ex_IR(ex_ir), .ex_npc(ex_npc), .instr_count(icnt)
    );

    execute_in_stage #(.DEPTH(4)) dut4 (
        .clock(clock), .reset(reset2), .run(run2),
        .Mem_Control(1'b1), .E_Control(6'h2A), .W_Control(2'b10),
        .IR(16'h1000), .npc_out(16'h3002), .en_decode(en2),
        .ex_ready(ready2), .ex_valid(valid2),
        .ex_Mem_Control(ex_mem2), .ex_E_Control(ex_e2), .ex_W_Control(ex_w2),
        .ex_IR(ex_ir2), .ex_npc(ex_npc2), .instr_count(icnt2)
    );

    // Side-band fields derived from IR so every captured field is distinguishable.
    function automatic logic [24:0] side(input logic [15:0] v);
        return {v[3], v[9:4] ^ 6'h2A, v[11:10], v + 16'h0002};
    endfunction

    typedef struct {
        bit          rst;
        bit          run;
        bit          rdy;
        logic [15:0] ir;
        bit          en;
        bit          vld;
        logic [15:0] exir;
        logic [15:0] icnt;
    } row_t;

    row_t rows[$];

    task automatic add(input bit r, input bit rn, input bit rd, input logic [15:0] v,
                       input bit en, input bit vld, input logic [15:0] exir,
                       input logic [15:0] ic);
        rows.push_back('{rst: r, run: rn, rdy: rd, ir: v, en: en, vld: vld,
                         exir: exir, icnt: ic});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_ir(input logic [15:0] v);
        logic [24:0] s;
        s     = side(v);
        ir    = v;
        mem_c = s[24];
        e_c   = s[23:18];
        w_c   = s[17:16];
        npc   = s[15:0];
    endtask

    localparam logic [15:0] J = 16'h7777;

    initial begin
        logic [24:0] exp_side;
        bit          hit;

        // Capture/pop stream with ex_ready high, then run drop
        add(0,1,1,J,       1,0,16'h0000,0);
        add(0,1,1,16'h1042,1,0,16'h0000,0);
        add(0,1,1,16'h5020,0,1,16'h1042,0);
        add(0,1,1,J,       1,1,16'h5020,1);
        add(0,0,1,16'h6283,0,0,16'h0000,2);
        add(0,0,1,J,       0,1,16'h6283,2);
        add(0,0,1,J,       0,0,16'h0000,3);
        // Back-pressure fills DEPTH, single pops, capture+pop with count=1
        add(0,1,0,16'h1111,1,0,16'h0000,3);
        add(0,1,0,16'h1A01,1,0,16'h0000,3);
        add(0,1,0,16'h1A02,0,1,16'h1A01,3);
        add(0,1,0,16'h1A03,0,1,16'h1A01,3);
        add(0,1,1,16'h1A03,0,1,16'h1A01,3);
        add(0,1,0,J,       1,1,16'h1A02,4);
        add(0,1,0,16'h1A04,0,1,16'h1A02,4);
        add(0,1,1,J,       0,1,16'h1A02,4);
        add(0,1,1,J,       1,1,16'h1A04,5);
        add(0,1,1,16'h1A05,1,0,16'h0000,6);
        add(0,1,1,16'h1A06,0,1,16'h1A05,6);
        add(0,1,0,J,       1,1,16'h1A06,7);
        // BR held for five cycles
        add(0,1,0,16'h0E05,0,1,16'h1A06,7);
        add(0,1,1,J,       0,1,16'h1A06,7);
        for (int k = 0; k < 5; k++) add(0,1,0,J,0,1,16'h0E05,8);
        add(0,1,1,J,       0,1,16'h0E05,8);
        add(0,1,0,J,       1,0,16'h0000,9);
        // JMP with an instruction already in flight
        add(0,1,0,16'hC1C0,1,0,16'h0000,9);
        add(0,1,0,16'h2345,0,1,16'hC1C0,9);
        add(0,1,1,J,       0,1,16'hC1C0,9);
        add(0,1,0,J,       1,1,16'h2345,10);
        // Reset mid-operation with a capture in flight
        add(1,1,0,16'h3333,0,1,16'h2345,10);
        add(0,1,0,16'h4444,1,0,16'h0000,0);
        add(0,1,1,16'h1B01,1,0,16'h0000,0);
        add(0,1,1,16'h1B02,0,1,16'h1B01,0);
        add(0,0,1,J,       0,1,16'h1B02,1);
        add(0,0,0,J,       0,0,16'h0000,2);
        // JSR then TRAP both counted as control
        add(0,1,0,J,       1,0,16'h0000,2);
        add(0,1,0,16'h4800,1,0,16'h0000,2);
        add(0,1,0,16'hF025,0,1,16'h4800,2);
        add(0,1,1,J,       0,1,16'h4800,2);
        add(0,1,1,J,       0,1,16'hF025,3);
        add(0,1,0,J,       1,0,16'h0000,4);

        reset = 1'b1; run = 1'b1; ex_ready = 1'b1;
        drive_ir(J);
        reset2 = 1'b1; run2 = 1'b0; ready2 = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset en_decode", 32'(en_decode), 32'd0);
        chk("reset ex_valid",  32'(ex_valid),  32'd0);
        chk("reset ex_IR",     32'(ex_ir),     32'd0);
        chk("reset fields",    32'({ex_mem, ex_e, ex_w, ex_npc}), 32'd0);
        chk("reset instr_count", 32'(icnt),    32'd0);

        foreach (rows[i]) begin
            @(posedge clock);
            #1;
            reset    = rows[i].rst;
            run      = rows[i].run;
            ex_ready = rows[i].rdy;
            drive_ir(rows[i].ir);
            @(negedge clock);
            exp_side = rows[i].vld ? side(rows[i].exir) : 25'd0;
            chk($sformatf("row%0d en_decode", i), 32'(en_decode), 32'(rows[i].en));
            chk($sformatf("row%0d ex_valid", i),  32'(ex_valid),  32'(rows[i].vld));
            chk($sformatf("row%0d ex_IR", i),     32'(ex_ir),     32'(rows[i].exir));
            chk($sformatf("row%0d fields", i), 32'({ex_mem, ex_e, ex_w, ex_npc}), 32'(exp_side));
            chk($sformatf("row%0d instr_count", i), 32'(icnt),    32'(rows[i].icnt));
        end

        // DEPTH=4 instance streams one pop per cycle up to the counter wrap
        @(posedge clock);
        #1;
        reset2 = 1'b0; run2 = 1'b1; ready2 = 1'b1;
        @(negedge clock);
        chk("d4 first en_decode", 32'(en2), 32'd1);
        hit = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clock);
            if (icnt2 == 16'hFFFF) begin
                hit = 1'b1;
                break;
            end
        end
        chk("d4 reached 0xFFFF", 32'(hit), 32'd1);
        chk("d4 valid at 0xFFFF", 32'(valid2), 32'd1);
        chk("d4 head IR", 32'(ex_ir2), 32'h1000);
        @(negedge clock);
        chk("d4 instr_count wrap", 32'(icnt2), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/execute_in_stage.md
EXECUTE_IN_STAGE -- requirements
Module: execute_in_stage

Interface
REQ-001 Parameter: DEPTH, default 2, number of decode_out entries buffered; legal range 2..4.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: run  input  1  global pipeline enable; en_decode forced low when 0.
REQ-005 Port: Mem_Control  input  1  decode-stage memory control.
REQ-006 Port: E_Control  input  6  decode-stage execute control.
REQ-007 Port: W_Control  input  2  decode-stage writeback control.
REQ-008 Port: IR  input  16  decoded instruction word.
REQ-009 Port: npc_out  input  16  next-PC from decode.
REQ-010 Port: en_decode  output  1  enable to decode stage; this block is the responder end of the decode_out bus.
REQ-011 Port: ex_ready  input  1  downstream accepts the head entry this cycle.
REQ-012 Port: ex_valid  output  1  head entry valid.
REQ-013 Port: ex_Mem_Control, ex_E_Control, ex_W_Control, ex_IR, ex_npc  output  1/6/2/16/16  head entry fields.
REQ-014 Port: instr_count  output  16  number of entries retired (popped) since reset.

Function
REQ-015 Capture timing SHALL be: en_decode=1 in cycle N -> decode outputs valid in cycle N+1 -> block writes all five fields into the buffer tail at the end of cycle N+1.
REQ-016 Register pending SHALL equal the previous cycle's en_decode; a capture occurs in each cycle where pending=1.
REQ-017 en_decode SHALL be combinational from registered state only: run AND (ctrl_cnt==0) AND (count + pending < DEPTH).
REQ-018 Buffer SHALL be a circular FIFO of DEPTH entries; head/tail pointers wrap from DEPTH-1 to 0.
REQ-019 ex_valid SHALL equal (count != 0); ex_* fields SHALL show the head entry when valid and all-zero when empty.
REQ-020 Pop SHALL occur when ex_valid AND ex_ready; ex_ready while empty SHALL have no effect.
REQ-021 Simultaneous capture and pop SHALL leave count unchanged and advance both pointers; capture into an empty buffer appears on ex_* the next cycle (no bypass).
REQ-022 Overflow SHALL be impossible by construction; a capture with count==DEPTH is a design error flagged by a verification assertion.
REQ-023 Control instruction = captured IR[15:12] in {0000 BR, 1100 JMP/RET, 0100 JSR, 1111 TRAP}; ctrl_cnt SHALL increment on capture of one and decrement on its pop (both same cycle: unchanged).
REQ-024 While ctrl_cnt != 0 en_decode SHALL be low; an instruction already pending when a control instruction is captured SHALL still be captured.
REQ-025 instr_count SHALL increment by 1 per pop and wrap 0xFFFF -> 0x0000.
REQ-026 run falling SHALL drop en_decode the same cycle; any pending capture still completes.

Reset
REQ-027 While reset=1: count=0, pending=0, ctrl_cnt=0, pointers=0, instr_count=0, en_decode=0, ex_valid=0, ex_* fields=0.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight entries; decode outputs in the cycle after reset deasserts are not captured.
REQ-029 First en_decode=1 SHALL occur in the first cycle with reset=0 and run=1.

Verification
REQ-030 Reset release, run=1, ex_ready=1, IR stream 0x1042,0x5020,0x6283 -> en_decode high from cycle 0; each IR on ex_IR 2 cycles after its en_decode; instr_count=3.
REQ-031 ex_ready=0, DEPTH=2, continuous ALU ops -> exactly 2 captures, en_decode low after 2 issued, count=2; ex_ready=1 one cycle -> one pop, en_decode re-asserts.
REQ-032 IR=0x0E05 (BR) captured, ex_ready=0 for 5 cycles -> en_decode low all 5 cycles; pop -> ctrl_cnt=0, en_decode high next cycle.
REQ-033 count=1, capture and pop same cycle -> count stays 1, ex_IR advances to new entry, pointers wrap correctly at DEPTH-1.
REQ-034 reset asserted with count=2 and pending=1 -> next cycle ex_valid=0, en_decode=0, instr_count=0; pending data not captured.
REQ-035 instr_count preloaded by 65535 pops, one more pop -> instr_count=0x0000.
